if_stage: RTL
=============

// Module: if_stage
// PURPOSE
//  Instruction-fetch stage: owns the PC register and drives the instruction-memory port.
//  Produces pc, pc_plus_4, exccode and badvaddr, which the IF/ID pipeline register captures.
//  Selects the next PC from three sources: sequential, branch/jump redirect from ID, or exception target on flush.
//  A branch redirect that arrives while IF is stalled is held in a pending latch, so it is never lost.
// PARAMETERS
//  RESET_VECTOR  `PC_INIT (32'hBFC0_0000)  PC value loaded on reset
// PORTS
//  cpu_clk_50M     in   1              single clock; all state updates on posedge
//  cpu_rst         in   1              reset, synchronous, active-high
//  stall           in   `STALL_BUS     pipeline stall vector; stall[0]==`STOP holds the PC
//  flush           in   1              exception/eret flush from CP0
//  cp0_excaddr     in   `INST_ADDR_BUS exception handler or EPC target, used when flush=1
//  branch_taken    in   1              ID resolved a taken branch/jump this cycle
//  branch_target   in   `INST_ADDR_BUS redirect target from ID
//  ice             out  1              instruction-memory enable
//  iaddr           out  `INST_ADDR_BUS instruction-memory address
//  pc              out  `INST_ADDR_BUS current fetch PC
//  pc_plus_4       out  `INST_ADDR_BUS pc + 4
//  if_exccode      out  `EXC_CODE_BUS  fetch exception code
//  if_badvaddr     out  `WORD_BUS      faulting fetch address
// BEHAVIOUR
//  State: ce_q, pc_q, pend_vld_q, pend_tgt_q.
//  Reset (cpu_rst=1 at posedge):
//   - ce_q=0, pc_q=RESET_VECTOR, pend_vld_q=0, pend_tgt_q=0.
//   - While ce_q=0: ice=0, if_exccode=`EXC_NONE, if_badvaddr=0.
//  First cycle after reset deasserts: ce_q=1, pc_q stays RESET_VECTOR, so the first fetch is the reset vector.
//  When ce_q=1, the next-PC priority per posedge is:
//   1. flush: pc_q<=cp0_excaddr; pend_vld_q<=0. Ignores stall and branch_taken.
//   2. stall[0]==`STOP: pc_q holds.
//      If branch_taken: pend_vld_q<=1, pend_tgt_q<=branch_target. A later branch overwrites the pending one.
//   3. branch_taken: pc_q<=branch_target; pend_vld_q<=0. The live redirect beats a pending one.
//   4. pend_vld_q: pc_q<=pend_tgt_q; pend_vld_q<=0.
//   5. Otherwise: pc_q<=pc_q+4.
//  Datapath outputs:
//   - pc=iaddr=pc_q, combinational from the register (zero added latency).
//   - pc_plus_4 = pc_q+4, mod 2^32: 32'hFFFF_FFFC -> 0, with no exception.
//  Reset asserted mid-stall or with a pending redirect: everything returns to reset values; the pending redirect is discarded.
// CONFIGURATION
//  IF_ADEL_CHECK_EN defined:
//   - pc_q[1:0]!=0 with ce_q=1 gives if_exccode=`EXC_ADEL, if_badvaddr=pc_q, ice=0 (no memory read).
//   - The PC still advances per the priority rules.
//  Undefined:
//   - if_exccode=`EXC_NONE and if_badvaddr=0 always; ice=ce_q.
// STRUCTURE
//  Shared defines header holds: `STALL_BUS, `STOP/`NOSTOP, `EXC_CODE_BUS, `EXC_NONE, `EXC_ADEL,
//   `INST_ADDR_BUS, `WORD_BUS, `PC_INIT, `ZERO_WORD.
//  One sub-module: if_redirect_buf, which holds pend_vld_q/pend_tgt_q with set, clear and flush inputs.
//  The next-PC mux and the exception check stay in if_stage.
// TESTING
//  1. Reset 3 cycles, release -> ice=0 in cycle 0, then ice=1 with pc=BFC0_0000, BFC0_0004, BFC0_0008.
//  2. stall[0]=STOP for 2 cycles at pc=BFC0_0010 -> pc holds BFC0_0010, then resumes at BFC0_0014.
//  3. branch_taken=1, target=BFC0_0100 during stall -> pc held; after stall release the next pc=BFC0_0100.
//  4. flush=1, excaddr=BFC0_0380, with stall=STOP and branch_taken=1 in the same cycle
//     -> pc=BFC0_0380 and the pending redirect is cleared.
//  5. IF_ADEL_CHECK_EN, branch_target=BFC0_0102 -> if_exccode=EXC_ADEL, if_badvaddr=BFC0_0102, ice=0.
//     Same stimulus with the macro undefined -> EXC_NONE, ice=1.
//  6. pc=FFFF_FFFC, no stall -> pc_plus_4=0 and the next pc=0000_0000.

Source files
------------

// File: rtl/if_stage_pkg.sv
// Shared fetch-stage definitions: bus-width macros, stall/exception encodings and fetch helpers.
// Compiled first so the macros are visible to every file that follows.
`ifndef IF_STAGE_DEFINES
`define IF_STAGE_DEFINES
`define STALL_BUS      5:0
`define STOP           1'b1
`define NOSTOP         1'b0
`define EXC_CODE_BUS   4:0
`define EXC_NONE       5'h10
`define EXC_ADEL       5'h04
`define INST_ADDR_BUS  31:0
`define WORD_BUS       31:0
`define PC_INIT        32'hBFC0_0000
`define ZERO_WORD      32'h0000_0000
`endif

package if_stage_pkg;

  localparam int          ADDR_W  = 32;
  localparam logic [31:0] PC_STEP = 32'd4;

  function automatic logic is_misaligned(input logic [ADDR_W-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/if_redirect_buf.sv
// Holds one branch redirect that arrived while fetch was stalled; a newer set overwrites it.
// Registered, one-cycle visibility; flush and reset discard the held target.
module if_redirect_buf
  import if_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              set,
  input  logic [ADDR_W-1:0] set_tgt,
  input  logic              clr,
  output logic              pend_vld,
  output logic [ADDR_W-1:0] pend_tgt
);

  logic              pend_vld_q, pend_vld_d;
  logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;

  always_comb begin
    pend_vld_d = pend_vld_q;
    pend_tgt_d = pend_tgt_q;
    if (flush) begin
      pend_vld_d = 1'b0;
    end else if (set) begin
      pend_vld_d = 1'b1;
      pend_tgt_d = set_tgt;
    end else if (clr) begin
      pend_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_vld_q <= 1'b0;
      pend_tgt_q <= '0;
    end else begin
      pend_vld_q <= pend_vld_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  assign pend_vld = pend_vld_q;
  assign pend_tgt = pend_tgt_q;

endmodule

// File: rtl/if_stage.sv
// Fetch stage: PC register, next-PC select (flush > stall > branch > pending > +4), zero-latency outputs.
// stall[0] holds the PC; IF_ADEL_CHECK_EN adds a misaligned-fetch (AdEL) check that suppresses ice.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = `PC_INIT
) (
  input  logic                   cpu_clk_50M,
  input  logic                   cpu_rst,
  input  logic [`STALL_BUS]      stall,
  input  logic                   flush,
  input  logic [`INST_ADDR_BUS]  cp0_excaddr,
  input  logic                   branch_taken,
  input  logic [`INST_ADDR_BUS]  branch_target,
  output logic                   ice,
  output logic [`INST_ADDR_BUS]  iaddr,
  output logic [`INST_ADDR_BUS]  pc,
  output logic [`INST_ADDR_BUS]  pc_plus_4,
  output logic [`EXC_CODE_BUS]   if_exccode,
  output logic [`WORD_BUS]       if_badvaddr
);

  logic                  ce_q, ce_d;
  logic [`INST_ADDR_BUS] pc_q, pc_d;
  logic                  stop;
  logic                  pend_vld;
  logic [`INST_ADDR_BUS] pend_tgt;
  logic                  pend_set, pend_clr;

  assign stop = (stall[0] == `STOP);

  // A stalled branch is parked; any unstalled cycle either consumes or supersedes it.
  assign pend_set = ce_q && !flush && stop && branch_taken;
  assign pend_clr = ce_q && !flush && !stop;

  if_redirect_buf u_redirect_buf (
    .clk      (cpu_clk_50M),
    .rst      (cpu_rst),
    .flush    (ce_q && flush),
    .set      (pend_set),
    .set_tgt  (branch_target),
    .clr      (pend_clr),
    .pend_vld (pend_vld),
    .pend_tgt (pend_tgt)
  );

  always_comb begin
    ce_d = 1'b1;
    pc_d = pc_q;
    if (ce_q) begin
      if (flush) begin
        pc_d = cp0_excaddr;
      end else if (stop) begin
        pc_d = pc_q;
      end else if (branch_taken) begin
        pc_d = branch_target;
      end else if (pend_vld) begin
        pc_d = pend_tgt;
      end else begin
        pc_d = pc_q + PC_STEP;
      end
    end
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (cpu_rst) begin
      ce_q <= 1'b0;
      pc_q <= RESET_VECTOR;
    end else begin
      ce_q <= ce_d;
      pc_q <= pc_d;
    end
  end

  assign pc        = pc_q;
  assign iaddr     = pc_q;
  assign pc_plus_4 = pc_q + PC_STEP;

`ifdef IF_ADEL_CHECK_EN
  logic adel;
  assign adel        = ce_q && is_misaligned(pc_q);
  assign ice         = ce_q && !adel;
  assign if_exccode  = adel ? `EXC_ADEL : `EXC_NONE;
  assign if_badvaddr = adel ? pc_q : `ZERO_WORD;
`else
  assign ice         = ce_q;
  assign if_exccode  = `EXC_NONE;
  assign if_badvaddr = `ZERO_WORD;
`endif

endmodule
